// File: rtl/spi_ctrl_master.sv
// rtl/spi_ctrl_master.sv - SPI mode-0 master serialising one control word per request
// Outputs are registered copies of decodes of the next state, so they track the FSM cycle-exactly.
module spi_ctrl_master #(
  parameter int FRAME_BITS  = 18,
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_GAP      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] req_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int BW    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [PW-1:0] P_SETUP = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] P_HALF  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] P_HOLD  = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] P_GAP   = PW'(CS_GAP - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state, state_d;
  logic [PW-1:0]           phase_cnt, phase_d;
  logic [BW-1:0]           bit_cnt, bit_d;
  logic [FRAME_BITS-1:0]   shreg, shreg_d;
  logic                    sclk_d, cs_n_d, busy_d, done_d, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= phase_d;
      bit_cnt   <= bit_d;
      shreg     <= shreg_d;
      sclk      <= sclk_d;
      cs_n      <= cs_n_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

  // mosi is the shift register MSB; clearing the register on GAP entry idles mosi low.
  assign mosi = shreg[FRAME_BITS-1];

  always_comb begin
    state_d = state;
    phase_d = (phase_cnt != '0) ? phase_cnt - PW'(1) : phase_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_SETUP;
          phase_d = P_SETUP;
          bit_d   = B_LAST;
          shreg_d = req_data;
        end
      end
      S_SETUP: begin
        if (phase_cnt == '0) begin
          state_d = S_LOW;
          phase_d = P_HALF;
        end
      end
      S_LOW: begin
        if (phase_cnt == '0) begin
          state_d = S_HIGH;
          phase_d = P_HALF;
        end
      end
      S_HIGH: begin
        if (phase_cnt == '0) begin
          if (bit_cnt != '0) begin
            state_d = S_LOW;
            phase_d = P_HALF;
            bit_d   = bit_cnt - BW'(1);
            shreg_d = {shreg[FRAME_BITS-2:0], 1'b0};
          end else begin
            state_d = S_HOLD;
            phase_d = P_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (phase_cnt == '0) begin
          state_d = S_GAP;
          phase_d = P_GAP;
          shreg_d = '0;
        end
      end
      S_GAP: begin
        if (phase_cnt == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    sclk_d  = (state_d == S_HIGH);
    cs_n_d  = (state_d == S_IDLE) || (state_d == S_GAP);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_GAP) && (state != S_GAP);
    ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb/tb_spi_ctrl_master.sv - directed bench for spi_ctrl_master with a behavioural SPI receiver
// Unit 0 uses default timing, unit 1 the minimum legal timing.
module tb_spi_ctrl_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic [17:0] req_data  [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        sclk      [2];
  logic        cs_n      [2];
  logic        mosi      [2];
  logic        busy      [2];
  logic        done      [2];

  spi_ctrl_master u_dut_def (
    .clk(clk), .rst(rst[0]), .req_data(req_data[0]), .req_valid(req_valid[0]),
    .req_ready(req_ready[0]), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .busy(busy[0]), .done(done[0])
  );

  spi_ctrl_master #(
    .FRAME_BITS(18), .HALF_PERIOD(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)
  ) u_dut_min (
    .clk(clk), .rst(rst[1]), .req_data(req_data[1]), .req_valid(req_valid[1]),
    .req_ready(req_ready[1]), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
    .busy(busy[1]), .done(done[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model: shifts mosi on each sclk rise, commits only a complete frame at cs_n rise.
  logic [17:0] rx        [2] = '{18'h0, 18'h0};
  logic [17:0] last_word [2] = '{18'h0, 18'h0};
  int          edges     [2] = '{0, 0};
  int          last_edges[2] = '{0, 0};
  int          frames    [2] = '{0, 0};
  int          dones     [2] = '{0, 0};
  int          glitch    [2] = '{0, 0};
  int          stray     [2] = '{0, 0};
  int          gc        [2] = '{0, 0};
  int          gap_min   [2] = '{999, 999};
  int          gap_max   [2] = '{0, 0};
  logic        ps        [2] = '{1'b0, 1'b0};
  logic        pm        [2] = '{1'b0, 1'b0};
  logic        pc        [2] = '{1'b1, 1'b1};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sclk[u] === 1'b1 && ps[u] === 1'b0) begin
        if (cs_n[u] !== 1'b0) stray[u]++;
        else begin
          rx[u] = {rx[u][16:0], mosi[u]};
          edges[u]++;
        end
      end
      if (sclk[u] === 1'b0 && ps[u] === 1'b1 && cs_n[u] === 1'b1 && pc[u] === 1'b1) stray[u]++;
      if (sclk[u] === 1'b1 && ps[u] === 1'b1 && mosi[u] !== pm[u]) glitch[u]++;
      if (cs_n[u] === 1'b1 && pc[u] === 1'b0) begin
        last_edges[u] = edges[u];
        if (edges[u] == 18) begin
          last_word[u] = rx[u];
          frames[u]++;
        end
        edges[u] = 0;
      end
      if (cs_n[u] === 1'b0 && pc[u] === 1'b1) edges[u] = 0;
      if (done[u] === 1'b1) dones[u]++;
      if (cs_n[u] === 1'b1 && busy[u] === 1'b1) gc[u]++;
      else if (gc[u] != 0) begin
        if (gc[u] < gap_min[u]) gap_min[u] = gc[u];
        if (gc[u] > gap_max[u]) gap_max[u] = gc[u];
        gc[u] = 0;
      end
      ps[u] = sclk[u];
      pm[u] = mosi[u];
      pc[u] = cs_n[u];
    end
  end

  // Called at a negedge; returns at the negedge where req_ready is back, lat = cycles since accept.
  task automatic send(input int u, input logic [17:0] d, input bit hold, output int lat);
    int n;
    req_data[u]  = d;
    req_valid[u] = 1'b1;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[u] !== 1'b1) check("accept_timeout", 0, 1);
    @(negedge clk);
    lat = 1;
    req_valid[u] = hold;
    while (req_ready[u] !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_edge(input int u, input int n_edges, input logic lvl, input string tag);
    int n;
    n = 0;
    while (!(edges[u] == n_edges && sclk[u] === lvl) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check(tag, 0, 1);
  endtask

  initial begin
    int lat;
    int f0, d0, n;
    for (int u = 0; u < 2; u++) begin
      rst[u]       = 1'b1;
      req_valid[u] = 1'b0;
      req_data[u]  = 18'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_n[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_done", done[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_ready", req_ready[0], 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready[0], 1);
    check("ready_after_rst_min", req_ready[1], 1);

    // Loopback of the reference control word
    f0 = frames[0]; d0 = dones[0];
    send(0, 18'h00FA2, 1'b0, lat);
    check("loop_latency", lat, 153);
    check("loop_word", last_word[0], 18'h00FA2);
    check("loop_edges", last_edges[0], 18);
    check("loop_frames", frames[0] - f0, 1);
    check("loop_done", dones[0] - d0, 1);

    // Back-to-back patterns with req_valid held
    gap_min[0] = 999; gap_max[0] = 0;
    send(0, 18'h3FFFF, 1'b1, lat);
    check("pat1_latency", lat, 153);
    check("pat1_word", last_word[0], 18'h3FFFF);
    send(0, 18'h00000, 1'b1, lat);
    check("pat2_latency", lat, 153);
    check("pat2_word", last_word[0], 18'h00000);
    send(0, 18'h2AAAA, 1'b0, lat);
    check("pat3_latency", lat, 153);
    check("pat3_word", last_word[0], 18'h2AAAA);
    repeat (3) @(negedge clk);
    check("gap_min", gap_min[0], 4);
    check("gap_max", gap_max[0], 4);
    check("mosi_stable_high", glitch[0], 0);

    // Request while busy is ignored
    f0 = frames[0]; d0 = dones[0];
    fork
      send(0, 18'h0F0F0, 1'b0, lat);
      begin
        wait_edge(0, 9, 1'b1, "busy_wait_timeout");
        req_data[0]  = 18'h12345;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
      end
    join
    check("busy_latency", lat, 153);
    check("busy_word", last_word[0], 18'h0F0F0);
    repeat (20) @(negedge clk);
    check("busy_frames", frames[0] - f0, 1);
    check("busy_done", dones[0] - d0, 1);
    check("busy_idle", busy[0], 0);

    // Reset in the middle of a frame
    f0 = frames[0]; d0 = dones[0];
    req_data[0]  = 18'h3C3C3;
    req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_edge(0, 8, 1'b0, "midrst_wait_timeout");
    check("midrst_pre_cs_n", cs_n[0], 0);
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", cs_n[0], 1);
    check("midrst_sclk", sclk[0], 0);
    check("midrst_done", done[0], 0);
    rst[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_commit", frames[0] - f0, 0);
    check("midrst_no_done", dones[0] - d0, 0);
    send(0, 18'h00055, 1'b0, lat);
    check("postrst_latency", lat, 153);
    check("postrst_word", last_word[0], 18'h00055);
    check("postrst_frames", frames[0] - f0, 1);

    // Minimum timing unit
    f0 = frames[1];
    send(1, 18'h1E0F3, 1'b0, lat);
    check("min_latency", lat, 76);
    check("min_word", last_word[1], 18'h1E0F3);
    check("min_edges", last_edges[1], 18);
    check("min_frames", frames[1] - f0, 1);
    check("min_mosi_stable", glitch[1], 0);

    check("stray_edges_def", stray[0], 0);
    check("stray_edges_min", stray[1], 0);
    check("final_mosi_stable", glitch[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
